// File: rtl/cmd_pkg.sv
// ---------------------------------------------------------------------------
// cmd_pkg
//  Shared types and helpers for the UART command dispatcher.
//  - opcode_t : command opcodes carried in cmd[15:12]
//  - state_t  : dispatcher FSM states
//  - field slice positions and extraction helpers for the 16-bit command word
//    laid out as {opcode[15:12], addr[11:8], data[7:0]}
// ---------------------------------------------------------------------------
package cmd_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_WRITE = 4'd1,
      OP_READ  = 4'd2,
      OP_GO    = 4'd3
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT_OP,
      S_RESP,
      S_WAIT_SENT
   } state_t;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int ADDR_MSB = 11;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   function automatic logic [3:0] cmd_opc(input logic [15:0] c);
      return c[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] cmd_addr(input logic [15:0] c);
      return c[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic [7:0] cmd_data(input logic [15:0] c);
      return c[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/cfg_regfile.sv
// ---------------------------------------------------------------------------
// cfg_regfile
//  16 x 8 configuration register file. Address 0 is a read-only constant
//  (VERSION); addresses 1..15 are flops cleared by reset.
//  Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      single write port (writes to address 0 are dropped)
//   raddr_a / rdata_a     combinational read port A (command execution)
//   raddr_b / rdata_b     combinational read port B (datapath cfg port)
// ---------------------------------------------------------------------------
module cfg_regfile #(
   parameter logic [7:0] VERSION = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr_a,
   output logic [7:0] rdata_a,
   input  logic [3:0] raddr_b,
   output logic [7:0] rdata_b
);

   logic [7:0] regs [1:15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 16; i++) regs[i] <= 8'h00;
      end else if (we) begin
         for (int i = 1; i < 16; i++) begin
            if (waddr == 4'(i)) regs[i] <= wdata;
         end
      end
   end

   // Read muxes default to VERSION so address 0 needs no storage.
   always_comb begin
      rdata_a = VERSION;
      rdata_b = VERSION;
      for (int i = 1; i < 16; i++) begin
         if (raddr_a == 4'(i)) rdata_a = regs[i];
         if (raddr_b == 4'(i)) rdata_b = regs[i];
      end
   end

endmodule

// File: rtl/cmd_dispatch.sv
// ---------------------------------------------------------------------------
// cmd_dispatch
//  Executes 16-bit commands from the UART command wrapper and returns exactly
//  one response byte per command.
//  Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd, cmd_rdy       command word and its level-valid flag
//   clr_cmd_rdy        1-cycle pulse consuming the command
//   resp, send_resp    response byte and its 1-cycle transmit strobe
//   resp_sent          UART transmit done (rising edge ends the command)
//   go, go_arg         downstream start pulse and its held argument
//   op_done            downstream completion (pulse or level)
//   cfg_addr, cfg_data combinational config read port for the datapath
//   busy               high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module cmd_dispatch
   import cmd_pkg::*;
#(
   parameter logic [7:0] ACK_CODE    = 8'hA5,
   parameter logic [7:0] NAK_CODE    = 8'hEE,
   parameter logic [7:0] TMO_CODE    = 8'hDD,
   parameter logic [7:0] VERSION     = 8'h01,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic [7:0]  resp,
   output logic        send_resp,
   input  logic        resp_sent,
   output logic        go,
   output logic [7:0]  go_arg,
   input  logic        op_done,
   input  logic [3:0]  cfg_addr,
   output logic [7:0]  cfg_data,
   output logic        busy
);

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t            state;
   logic [15:0]       cmd_q;
   logic [TMR_W-1:0]  timer;
   logic              sent_q;

   logic [3:0] opc;
   logic [3:0] addr;
   logic [7:0] data;
   logic       rf_we;
   logic [7:0] rf_rdata;
   logic       sent_rise;

   assign opc  = cmd_opc(cmd_q);
   assign addr = cmd_addr(cmd_q);
   assign data = cmd_data(cmd_q);

   // The register write lands at the end of EXEC, so the cfg port keeps
   // showing the old value during that cycle.
   assign rf_we     = (state == S_EXEC) && (opc == OP_WRITE) && (addr != 4'd0);
   assign sent_rise = resp_sent && !sent_q;
   assign busy      = (state != S_IDLE);

   cfg_regfile #(
      .VERSION (VERSION)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (addr),
      .wdata   (data),
      .raddr_a (addr),
      .rdata_a (rf_rdata),
      .raddr_b (cfg_addr),
      .rdata_b (cfg_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cmd_q       <= 16'h0000;
         timer       <= '0;
         sent_q      <= 1'b0;
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
         go          <= 1'b0;
         go_arg      <= 8'h00;
         resp        <= 8'h00;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
         go          <= 1'b0;
         sent_q      <= resp_sent;

         case (state)
            S_IDLE: begin
               if (cmd_rdy) begin
                  cmd_q       <= cmd;
                  clr_cmd_rdy <= 1'b1;
                  state       <= S_EXEC;
               end
            end

            S_EXEC: begin
               state <= S_RESP;
               case (opc)
                  OP_NOP:   resp <= ACK_CODE;
                  OP_WRITE: resp <= (addr == 4'd0) ? NAK_CODE : ACK_CODE;
                  OP_READ:  resp <= rf_rdata;
                  OP_GO: begin
                     go     <= 1'b1;
                     go_arg <= data;
                     timer  <= '0;
                     state  <= S_WAIT_OP;
                  end
                  default:  resp <= NAK_CODE;
               endcase
            end

            S_WAIT_OP: begin
               timer <= timer + TMR_W'(1);
               // op_done is checked first so it wins over a same-cycle timeout.
               if (op_done) begin
                  resp  <= ACK_CODE;
                  state <= S_RESP;
               end else if (timer == TMR_LAST) begin
                  resp  <= TMO_CODE;
                  state <= S_RESP;
               end
            end

            S_RESP: begin
               send_resp <= 1'b1;
               state     <= S_WAIT_SENT;
            end

            S_WAIT_SENT: begin
               if (sent_rise) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;

   localparam int         TMO_LIMIT = 16;
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;
   localparam logic [7:0] TMO = 8'hDD;
   localparam logic [7:0] VER = 8'h01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd = 16'h0000;
   logic        cmd_rdy = 1'b0;
   logic        clr_cmd_rdy;
   logic [7:0]  resp;
   logic        send_resp;
   logic        resp_sent = 1'b0;
   logic        go;
   logic [7:0]  go_arg;
   logic        op_done = 1'b0;
   logic [3:0]  cfg_addr = 4'h0;
   logic [7:0]  cfg_data;
   logic        busy;

   int checks = 0;
   int failures = 0;

   // Reference state: config contents (index 0 unused) and last GO argument.
   logic [7:0] ref_regs [16];
   logic [7:0] ref_go_arg;

   cmd_dispatch #(
      .TIMEOUT_CYC (TMO_LIMIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .go          (go),
      .go_arg      (go_arg),
      .op_done     (op_done),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_cfg(input logic [3:0] a);
      return (a == 4'd0) ? VER : ref_regs[a];
   endfunction

   // Expected response byte; d is the WAIT_OP cycle index (0 = go cycle)
   // in which op_done is presented for a GO.
   function automatic logic [7:0] ref_resp(input logic [15:0] c, input int d);
      logic [3:0] op;
      logic [3:0] a;
      op = c[15:12];
      a  = c[11:8];
      case (op)
         4'd0:    return ACK;
         4'd1:    return (a == 4'd0) ? NAK : ACK;
         4'd2:    return ref_cfg(a);
         4'd3:    return (d < TMO_LIMIT) ? ACK : TMO;
         default: return NAK;
      endcase
   endfunction

   // Issues one command from an IDLE cycle and runs until send_resp is seen.
   task automatic start_cmd(input logic [15:0] c, input int d, output logic [7:0] exp_r);
      logic [3:0] op;
      logic [3:0] a;
      int cnt;
      int exp_ticks;
      op = c[15:12];
      a  = c[11:8];
      exp_r = ref_resp(c, d);

      cmd = c;
      cmd_rdy = 1'b1;
      tick();
      chk("clr_pulse", 16'(clr_cmd_rdy), 16'd1);
      chk("busy_exec", 16'(busy), 16'd1);
      cmd = 16'($urandom);
      if (op == 4'd1 && a != 4'd0) begin
         cfg_addr = a;
         #1;
         chk("cfg_old", 16'(cfg_data), 16'(ref_cfg(a)));
      end
      tick();
      cmd_rdy = 1'b0;
      chk("clr_once", 16'(clr_cmd_rdy), 16'd0);
      if (op == 4'd1 && a != 4'd0) begin
         ref_regs[a] = c[7:0];
         chk("cfg_new", 16'(cfg_data), 16'(ref_cfg(a)));
      end

      if (op == 4'd3) begin
         chk("go_pulse", 16'(go), 16'd1);
         ref_go_arg = c[7:0];
         chk("go_arg", 16'(go_arg), 16'(ref_go_arg));
         exp_ticks = ((d < TMO_LIMIT - 1) ? d : TMO_LIMIT - 1) + 2;
         cnt = 0;
         while (cnt < 60 && !send_resp) begin
            op_done = (cnt == d);
            tick();
            op_done = 1'b0;
            cnt++;
            chk("go_once", 16'(go), 16'd0);
         end
         chk("go_latency", 16'(cnt), 16'(exp_ticks));
      end else begin
         chk("no_go", 16'(go), 16'd0);
         chk("send_early", 16'(send_resp), 16'd0);
         op_done = 1'($urandom);
         tick();
         op_done = 1'b0;
         chk("send_lat3", 16'(send_resp), 16'd1);
      end
      chk("resp", 16'(resp), 16'(exp_r));
      chk("go_arg_hold", 16'(go_arg), 16'(ref_go_arg));
      $display("txn cmd=%h op_done_at=%0d resp=%h expected=%h", c, d, resp, exp_r);
   endtask

   // Completes the UART handshake and leaves the bench in the first IDLE cycle.
   task automatic finish_sent(input logic [7:0] exp_r, input int gap);
      tick();
      chk("send_once", 16'(send_resp), 16'd0);
      for (int i = 0; i < gap; i++) begin
         chk("resp_hold", 16'(resp), 16'(exp_r));
         chk("busy_wait", 16'(busy), 16'd1);
         chk("no_consume", 16'(clr_cmd_rdy), 16'd0);
         tick();
      end
      resp_sent = 1'b1;
      tick();
      chk("idle_after_sent", 16'(busy), 16'd0);
      resp_sent = 1'b0;
      cfg_addr = 4'($urandom);
      #1;
      chk("cfg_port", 16'(cfg_data), 16'(ref_cfg(cfg_addr)));
   endtask

   initial begin
      logic [7:0]  r;
      logic [15:0] c;
      logic [3:0]  op;
      int          sel;
      int          d;
      int          strobes;

      for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
      ref_go_arg = 8'h00;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_go", 16'(go), 16'd0);
      chk("rst_send", 16'(send_resp), 16'd0);
      chk("rst_clr", 16'(clr_cmd_rdy), 16'd0);
      chk("rst_resp", 16'(resp), 16'd0);
      chk("rst_go_arg", 16'(go_arg), 16'd0);
      chk("rst_cfg0", 16'(cfg_data), 16'(VER));
      rst_n = 1'b1;
      tick();

      // Directed commands
      start_cmd(16'h1355, 0, r);  finish_sent(r, 1);
      start_cmd(16'h2300, 0, r);  chk("read_back_55", 16'(r), 16'h55);  finish_sent(r, 0);
      start_cmd(16'h10FF, 0, r);  finish_sent(r, 2);
      start_cmd(16'h2000, 0, r);  chk("read_version", 16'(r), 16'h01);  finish_sent(r, 0);
      start_cmd(16'h7000, 0, r);  finish_sent(r, 1);
      start_cmd(16'h3042, 10, r); finish_sent(r, 1);
      start_cmd(16'h3011, 99, r); finish_sent(r, 0);
      start_cmd(16'h3022, 15, r); finish_sent(r, 0);
      start_cmd(16'h3033, 16, r); finish_sent(r, 0);
      start_cmd(16'h3044, 0, r);  finish_sent(r, 0);

      // Second command held while the first waits for resp_sent
      start_cmd(16'h119C, 0, r);
      cmd = 16'h2100;
      cmd_rdy = 1'b1;
      finish_sent(r, 3);
      chk("pend_not_yet", 16'(clr_cmd_rdy), 16'd0);
      start_cmd(16'h2100, 0, r);
      chk("pend_read_9c", 16'(r), 16'h9C);
      finish_sent(r, 1);

      // Randomized commands
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 5);
         op  = (sel < 4) ? 4'(sel) : 4'($urandom_range(4, 15));
         c   = {op, 4'($urandom), 8'($urandom)};
         d   = $urandom_range(0, 20);
         start_cmd(c, d, r);
         if ($urandom_range(0, 3) == 0) begin
            cmd = 16'($urandom);
            cmd_rdy = 1'b1;
         end
         finish_sent(r, $urandom_range(0, 3));
      end
      cmd_rdy = 1'b0;

      // Make sure address 1 holds a non-zero value before the reset test
      start_cmd(16'h11C3, 0, r);  finish_sent(r, 0);

      // Reset asserted during WAIT_OP
      cmd = 16'h3077;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      repeat (5) tick();
      chk("pre_rst_busy", 16'(busy), 16'd1);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
      ref_go_arg = 8'h00;
      chk("mid_rst_busy", 16'(busy), 16'd0);
      chk("mid_rst_go", 16'(go), 16'd0);
      chk("mid_rst_send", 16'(send_resp), 16'd0);
      chk("mid_rst_clr", 16'(clr_cmd_rdy), 16'd0);
      chk("mid_rst_go_arg", 16'(go_arg), 16'(ref_go_arg));
      cfg_addr = 4'd1;
      #1;
      chk("mid_rst_cfg1", 16'(cfg_data), 16'(ref_cfg(4'd1)));
      tick();
      rst_n = 1'b1;
      strobes = 0;
      op_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (send_resp || go || busy) strobes++;
      end
      op_done = 1'b0;
      chk("post_rst_quiet", 16'(strobes), 16'd0);
      chk("post_rst_cfg1", 16'(cfg_data), 16'(ref_cfg(4'd1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
